// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_pkg;

    // Controller states; encodings are fixed so they stay stable across revisions.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Subtraction runs as a + ~b + 1, so the carry flop is seeded with 1.
    localparam logic SUB_CARRY_SEED = 1'b1;

endpackage

// File: rtl/half_adder.sv
// Half adder primitive: sum = a ^ b, carry = a & b.
// Latency: combinational.
// Backpressure: none.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half adders and an OR gate.
// Latency: combinational.
// Backpressure: none.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    // First stage adds the operand bits.
    half_adder u_ha1 (
        .a     (a),
        .b     (b),
        .sum   (ha1_sum),
        .carry (ha1_carry)
    );

    // Second stage folds in the incoming carry.
    half_adder u_ha2 (
        .a     (ha1_sum),
        .b     (ci),
        .sum   (s),
        .carry (ha2_carry)
    );

    // Both half-adder carries can never be high together, so OR is the majority.
    assign co = ha1_carry | ha2_carry;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit add/subtract sequencer reusing a single full-adder cell.
// Latency: done pulses W cycles after the accepting edge; next accept W+2 cycles later.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CNT_W = $clog2(W);

    state_t           state;
    state_t           next_state;

    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     r_sh;
    logic [W-1:0]     sum_q;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;

    logic             cell_s;
    logic             cell_c;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && start;
    assign last_bit = (cnt == CNT_W'(W - 1));

    // The shared cell always looks at the LSBs of the operand shifters and the carry flop.
    serial_fa_cell u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: IDLE waits for start, SHIFT runs W bits, DONE lasts one cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start)    next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:                  next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Operand load on accept, then one bit per cycle through the cell while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? SUB_CARRY_SEED : cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {cell_s, r_sh[W-1:1]};
            carry <= cell_c;
            // Hold on the final bit so the counter never leaves 0..W-1 for non-power-of-two W.
            if (!last_bit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Result capture only on the last bit, so partial sums never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if ((state == SHIFT) && last_bit) begin
            sum_q  <= {cell_s, r_sh[W-1:1]};
            cout_q <= cell_c;
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at W=8 and W=16, plus the full-adder cell.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel16;

    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    logic        busy_m, done_m, cout_m;
    logic [31:0] sum_m;

    logic        ca, cb, cci, cs, cco;

    int          n_checks;
    int          n_fail;
    logic [63:0] prev_sum [2];

    serial_add_ctrl #(.W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start & ~sel16),
        .sub   (sub),
        .cin   (cin),
        .a     (a[7:0]),
        .b     (b[7:0]),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start & sel16),
        .sub   (sub),
        .cin   (cin),
        .a     (a[15:0]),
        .b     (b[15:0]),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    serial_fa_cell u_cell (
        .a  (ca),
        .b  (cb),
        .ci (cci),
        .s  (cs),
        .co (cco)
    );

    always_comb begin
        busy_m = sel16 ? busy16 : busy8;
        done_m = sel16 ? done16 : done8;
        cout_m = sel16 ? cout16 : cout8;
        sum_m  = sel16 ? {16'd0, sum16} : {24'd0, sum8};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One operation; reference result is plain modular arithmetic on the operands.
    task automatic run_op(input logic op_sub, input logic op_cin,
                          input logic [31:0] op_a, input logic [31:0] op_b,
                          input bit repulse);
        int          w;
        logic [63:0] mask, ea, eb, full, exp_sum, exp_cout;
        int          busy_cnt, done_cnt, done_idx;
        logic [31:0] got_sum;
        logic        got_cout;
        bit          leaked;

        w    = sel16 ? 16 : 8;
        mask = (64'd1 << w) - 64'd1;
        ea   = {32'd0, op_a} & mask;
        eb   = {32'd0, op_b} & mask;
        if (op_sub) begin
            exp_sum  = (ea - eb) & mask;
            exp_cout = (ea >= eb) ? 64'd1 : 64'd0;
        end else begin
            full     = ea + eb + {63'd0, op_cin};
            exp_sum  = full & mask;
            exp_cout = (full >> w) & 64'd1;
        end

        busy_cnt = 0;
        done_cnt = 0;
        done_idx = 0;
        got_sum  = '0;
        got_cout = 1'b0;
        leaked   = 1'b0;

        @(negedge clk);
        start = 1'b1;
        sub   = op_sub;
        cin   = op_cin;
        a     = op_a;
        b     = op_b;
        for (int i = 1; i <= w + 4; i++) begin
            @(negedge clk);
            if (busy_m) busy_cnt++;
            if (done_m) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_idx = i;
                    got_sum  = sum_m;
                    got_cout = cout_m;
                end
            end else if (done_cnt == 0 && {32'd0, sum_m} != prev_sum[sel16]) begin
                leaked = 1'b1;
            end
            start = repulse && (i == 3 || i == 9);
            a     = $urandom;
            b     = $urandom;
            sub   = 1'($urandom);
            cin   = 1'($urandom);
        end
        start = 1'b0;

        check("busy_cycles", 64'(busy_cnt), 64'(w));
        check("done_count", 64'(done_cnt), 64'd1);
        check("done_latency", 64'(done_idx), 64'(w + 1));
        check("sum", {32'd0, got_sum}, exp_sum);
        check("cout", {63'd0, got_cout}, exp_cout);
        check("sum_held", {63'd0, leaked}, 64'd0);
        prev_sum[sel16] = exp_sum;
    endtask

    // start held high: one accept per W+2 cycles.
    task automatic held_high();
        int          w;
        int          q[$];
        logic [63:0] mask, exp_sum;
        logic [31:0] last_sum;

        w        = sel16 ? 16 : 8;
        mask     = (64'd1 << w) - 64'd1;
        last_sum = '0;
        @(negedge clk);
        start   = 1'b1;
        sub     = 1'b0;
        cin     = 1'b0;
        a       = $urandom;
        b       = $urandom;
        exp_sum = (({32'd0, a} & mask) + ({32'd0, b} & mask)) & mask;
        for (int i = 1; i <= 3 * (w + 2) + 1; i++) begin
            @(negedge clk);
            if (done_m) begin
                q.push_back(i);
                last_sum = sum_m;
            end
        end
        start = 1'b0;
        repeat (w + 4) @(negedge clk);

        check("held_done_count", 64'(q.size()), 64'd3);
        if (q.size() == 3) begin
            check("held_first_done", 64'(q[0]), 64'(w + 1));
            check("held_spacing1", 64'(q[1] - q[0]), 64'(w + 2));
            check("held_spacing2", 64'(q[2] - q[1]), 64'(w + 2));
        end
        check("held_sum", {32'd0, last_sum}, exp_sum);
        prev_sum[sel16] = exp_sum;
    endtask

    // Reset in the middle of SHIFT must clear everything at once with no done pulse.
    task automatic reset_mid_op();
        bit seen_done;

        seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = 32'h0000_0021;
        b     = 32'h0000_0042;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy_m}, 64'd0);
        check("rst_done", {63'd0, done_m}, 64'd0);
        check("rst_sum", {32'd0, sum_m}, 64'd0);
        check("rst_cout", {63'd0, cout_m}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_m) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        check("rst_no_done", {63'd0, seen_done}, 64'd0);
        prev_sum[0] = '0;
        prev_sum[1] = '0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        prev_sum[0] = '0;
        prev_sum[1] = '0;
        rst_n       = 1'b0;
        start       = 1'b0;
        sub         = 1'b0;
        cin         = 1'b0;
        a           = '0;
        b           = '0;
        sel16       = 1'b0;
        ca          = 1'b0;
        cb          = 1'b0;
        cci         = 1'b0;

        // Full-adder cell over every input combination.
        for (int i = 0; i < 8; i++) begin
            {ca, cb, cci} = 3'(i);
            #1;
            check("fa_cell", {62'd0, cco, cs}, 64'(ca) + 64'(cb) + 64'(cci));
        end

        repeat (2) @(negedge clk);
        check("reset_busy8", {63'd0, busy8}, 64'd0);
        check("reset_done8", {63'd0, done8}, 64'd0);
        check("reset_sum8", {56'd0, sum8}, 64'd0);
        check("reset_cout8", {63'd0, cout8}, 64'd0);
        check("reset_busy16", {63'd0, busy16}, 64'd0);
        check("reset_done16", {63'd0, done16}, 64'd0);
        check("reset_sum16", {48'd0, sum16}, 64'd0);
        check("reset_cout16", {63'd0, cout16}, 64'd0);
        rst_n = 1'b1;

        // Directed cases at W=8.
        run_op(1'b0, 1'b0, 32'h35, 32'h4A, 1'b0);
        run_op(1'b0, 1'b0, 32'hFF, 32'h01, 1'b0);
        run_op(1'b0, 1'b1, 32'hFF, 32'h00, 1'b0);
        run_op(1'b1, 1'b0, 32'h10, 32'h01, 1'b0);
        run_op(1'b1, 1'b0, 32'h00, 32'h01, 1'b0);
        run_op(1'b0, 1'b1, 32'h12, 32'h34, 1'b1);
        held_high();
        run_op(1'b0, 1'b0, 32'h5A, 32'h33, 1'b0);
        reset_mid_op();
        run_op(1'b1, 1'b0, 32'hC3, 32'h3C, 1'b0);

        // Random operations at both widths.
        for (int n = 0; n < 1000; n++) begin
            run_op(1'($urandom), 1'($urandom), $urandom, $urandom, 1'b0);
        end
        sel16 = 1'b1;
        held_high();
        for (int n = 0; n < 1000; n++) begin
            run_op(1'($urandom), 1'($urandom), $urandom, $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
